tx_frame_scheduler: RTL and testbench
=====================================

Name: tx_frame_scheduler

Overview:
- Shares the single MAC transmit path between two frame sources (bridge port A and port B).
- Grants sources round-robin, one whole frame at a time.
- Streams the granted frame's bytes to the MAC with a valid/ready handshake, zero-pads frames shorter than MIN_LEN, marks the last byte, and enforces an inter-frame gap before the next grant.

Parameters:
- MIN_LEN, 64, minimum frame length in bytes; shorter frames are zero-padded to it.
- MAX_LEN, 1518, maximum legal frame length in bytes.
- IFG_CYCLES, 12, idle clock cycles inserted after each frame's last byte is accepted.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- req_a  in  1  port A requests to send a frame; held until granted or rejected
- len_a  in  16  port A frame length in bytes; stable while req_a is high
- data_a  in  8  port A next byte
- valid_a  in  1  data_a is valid
- rd_a  out  1  port A byte consumed this cycle (combinational)
- req_b, len_b, data_b, valid_b, rd_b: same as port A, for port B
- gnt  out  2  one-hot grant; bit0 = A, bit1 = B
- mac_data  out  8  registered byte to the MAC
- mac_valid  out  1  mac_data is valid
- mac_last  out  1  mac_data is the final byte of the frame, including padding
- mac_ready  in  1  MAC accepts mac_data this cycle
- busy  out  1  state is not IDLE
- err_len  out  1  one-cycle pulse: a request was rejected for illegal length

Behaviour:
- Reset (rst low, async): state IDLE; gnt, mac_data, mac_valid, mac_last, err_len, busy all 0; counters 0; rr pointer set so A wins the first tie.
- Reset mid-frame aborts the frame with no mac_last.
- States: IDLE, SEND, PAD, IFG.
- IDLE:
  - Requests are sampled each cycle; if both are high, the port not granted last wins.
  - Selected len = 0 or len > MAX_LEN: pulse err_len for 1 cycle, no grant, stay IDLE, rr pointer moves past that port. The source must drop req on err_len.
  - Legal len: latch it into len_lat, set gnt one-hot, clear cnt, go to SEND on the next edge. Grant latency from req to gnt is 1 cycle.
- Output register load enable: load = !mac_valid || mac_ready.
- SEND:
  - rd_x = gnt_x & valid_x & load. On rd_x, mac_data <= data_x, mac_valid <= 1, cnt <= cnt + 1.
  - If load is high but valid_x is low, mac_valid <= 0 (a bubble is allowed).
  - On the byte where cnt == len_lat - 1:
    - len_lat >= MIN_LEN: mac_last <= 1; wait for its acceptance.
    - Otherwise: go to PAD.
- PAD:
  - On each load, mac_data <= 8'h00, mac_valid <= 1, cnt <= cnt + 1.
  - The byte where cnt == MIN_LEN - 1 carries mac_last.
  - rd_x stays 0 throughout PAD.
- Frame end: when mac_valid & mac_ready & mac_last, clear mac_valid/mac_last, clear gnt, record the granted port in the rr pointer, load the gap counter with IFG_CYCLES, enter IFG.
- IFG: decrement the gap counter each cycle; at 0 go to IDLE. Requests are ignored during IFG.
- Held data: mac_data/mac_valid/mac_last are held stable while mac_valid & !mac_ready.
- Requests mid-frame:
  - req of the granted port dropping mid-frame is ignored; the frame completes to len_lat bytes.
  - The other port's req has no effect until IDLE.
- cnt is 16 bits and never wraps: it is bounded by MAX_LEN.
- len_x changing after grant has no effect.
- Exactly one rd pulse per source byte; a frame never consumes more than len_lat bytes from its source.

Test Plan:
- A only, len_a = 100, valid_a and mac_ready always 1:
  - gnt = 01 one cycle after req_a.
  - 100 bytes appear in order, mac_last on byte 100.
  - IFG of 12 cycles, then IDLE.
- B only, len_b = 20:
  - 20 source bytes, then 44 bytes of 8'h00; mac_last on byte 64.
  - rd_b pulses exactly 20 times.
- req_a and req_b both held, len = 64 each:
  - Grants run A, B, A, B.
  - Each frame is followed by exactly 12 idle cycles.
- len_a = 80; mac_ready low for 5 cycles at byte 10; valid_a low for 3 cycles at byte 40:
  - mac_data holds byte 10 stable while mac_ready is low.
  - A bubble appears around byte 40; no byte is lost or duplicated; total is 80.
- len_a = 0, then len_a = 2000:
  - Each causes a one-cycle err_len pulse, with gnt staying 00.
  - A following legal req_b is granted.
- rst low at byte 30 of a 100-byte frame:
  - All outputs go to 0 immediately; no mac_last is emitted.
  - After rst goes high, a new req_a is granted and sends from byte 1.

Source files
------------

// File: rtl/tx_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tx_frame_scheduler
//
// Shares one MAC transmit path between two frame sources (bridge ports A/B).
// Sources are granted round-robin, one whole frame at a time. The granted
// frame is streamed into a registered valid/ready output stage. Frames shorter
// than MIN_LEN are zero-padded, the final byte carries mac_last, and IFG_CYCLES
// idle cycles follow every frame before the next grant is considered.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   req_x, len_x               frame request and its length (held until grant/reject)
//   data_x, valid_x            source byte stream
//   rd_x                       source byte consumed this cycle (combinational)
//   gnt[1:0]                   one-hot grant, bit0 = A, bit1 = B
//   mac_data/valid/last/ready  registered byte stream to the MAC
//   busy                       scheduler is not idle
//   err_len                    one-cycle pulse: request rejected for illegal length
// -----------------------------------------------------------------------------
module tx_frame_scheduler #(
   parameter int MIN_LEN    = 64,
   parameter int MAX_LEN    = 1518,
   parameter int IFG_CYCLES = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a,
   input  logic [15:0] len_a,
   input  logic [7:0]  data_a,
   input  logic        valid_a,
   output logic        rd_a,
   input  logic        req_b,
   input  logic [15:0] len_b,
   input  logic [7:0]  data_b,
   input  logic        valid_b,
   output logic        rd_b,
   output logic [1:0]  gnt,
   output logic [7:0]  mac_data,
   output logic        mac_valid,
   output logic        mac_last,
   input  logic        mac_ready,
   output logic        busy,
   output logic        err_len
);

   typedef enum logic [1:0] {IDLE, SEND, PAD, IFG} state_t;

   state_t      state, state_nxt;
   logic [1:0]  gnt_nxt;
   logic [7:0]  data_nxt;
   logic        valid_nxt, last_nxt, err_nxt;
   logic [15:0] len_lat, len_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [15:0] gap, gap_nxt;
   // 1 when B was the port served (or rejected) last, so A wins the next tie
   logic        last_b, last_b_nxt;

   // ---------------------------------------------------------------------------
   // Arbitration: single requester wins outright, a tie goes to the port
   // that was not served last.
   // ---------------------------------------------------------------------------
   logic        req_any, sel_b, len_bad;
   logic [15:0] len_sel;

   assign req_any = req_a | req_b;
   assign sel_b   = req_b & (~req_a | ~last_b);
   assign len_sel = sel_b ? len_b : len_a;
   assign len_bad = (len_sel == 16'd0) || (len_sel > 16'(MAX_LEN));

   // ---------------------------------------------------------------------------
   // Output stage handshake and source selection
   // ---------------------------------------------------------------------------
   logic       load, frame_end, more, src_valid, take, long_frame;
   logic [7:0] src_data;

   assign load       = ~mac_valid | mac_ready;
   assign frame_end  = mac_valid & mac_ready & mac_last;
   // once cnt reaches len_lat the source is exhausted; this keeps rd quiet
   // while the final byte waits for acceptance
   assign more       = (cnt != len_lat);
   assign src_valid  = |(gnt & {valid_b, valid_a});
   assign src_data   = gnt[1] ? data_b : data_a;
   assign long_frame = (len_lat >= 16'(MIN_LEN));
   assign take       = (state == SEND) & load & more & src_valid;

   assign rd_a = take & gnt[0];
   assign rd_b = take & gnt[1];
   assign busy = (state != IDLE);

   // ---------------------------------------------------------------------------
   // Next-state / datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      gnt_nxt    = gnt;
      data_nxt   = mac_data;
      valid_nxt  = mac_valid;
      last_nxt   = mac_last;
      err_nxt    = 1'b0;
      len_nxt    = len_lat;
      cnt_nxt    = cnt;
      gap_nxt    = gap;
      last_b_nxt = last_b;

      case (state)
         IDLE: begin
            if (req_any) begin
               if (len_bad) begin
                  err_nxt    = 1'b1;
                  last_b_nxt = sel_b;
               end else begin
                  len_nxt   = len_sel;
                  gnt_nxt   = sel_b ? 2'b10 : 2'b01;
                  cnt_nxt   = 16'd0;
                  state_nxt = SEND;
               end
            end
         end

         SEND: begin
            if (frame_end) begin
               valid_nxt  = 1'b0;
               last_nxt   = 1'b0;
               gnt_nxt    = 2'b00;
               last_b_nxt = gnt[1];
               gap_nxt    = 16'(IFG_CYCLES);
               state_nxt  = (IFG_CYCLES == 0) ? IDLE : IFG;
            end else if (load && more) begin
               if (src_valid) begin
                  data_nxt  = src_data;
                  valid_nxt = 1'b1;
                  cnt_nxt   = cnt + 16'd1;
                  if (cnt == len_lat - 16'd1) begin
                     // short frames hand over to padding; long ones end here
                     if (long_frame) last_nxt  = 1'b1;
                     else            state_nxt = PAD;
                  end
               end else begin
                  valid_nxt = 1'b0;   // source bubble
               end
            end
         end

         PAD: begin
            if (frame_end) begin
               valid_nxt  = 1'b0;
               last_nxt   = 1'b0;
               gnt_nxt    = 2'b00;
               last_b_nxt = gnt[1];
               gap_nxt    = 16'(IFG_CYCLES);
               state_nxt  = (IFG_CYCLES == 0) ? IDLE : IFG;
            end else if (load) begin
               data_nxt  = 8'h00;
               valid_nxt = 1'b1;
               cnt_nxt   = cnt + 16'd1;
               last_nxt  = (cnt == 16'(MIN_LEN - 1));
            end
         end

         IFG: begin
            // gap counts IFG_CYCLES..1, so exactly IFG_CYCLES cycles are spent here
            gap_nxt = gap - 16'd1;
            if (gap <= 16'd1) begin
               gap_nxt   = 16'd0;
               state_nxt = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         gnt       <= 2'b00;
         mac_data  <= 8'h00;
         mac_valid <= 1'b0;
         mac_last  <= 1'b0;
         err_len   <= 1'b0;
         len_lat   <= 16'd0;
         cnt       <= 16'd0;
         gap       <= 16'd0;
         last_b    <= 1'b1;
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         mac_data  <= data_nxt;
         mac_valid <= valid_nxt;
         mac_last  <= last_nxt;
         err_len   <= err_nxt;
         len_lat   <= len_nxt;
         cnt       <= cnt_nxt;
         gap       <= gap_nxt;
         last_b    <= last_b_nxt;
      end
   end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tx_frame_scheduler
//
// Directed bench for tx_frame_scheduler. Each source is a counter-backed byte
// stream (A: idx+0x11, B: idx+0x93) that advances on rd. A negedge monitor
// records accepted MAC bytes, grant order, IFG run lengths, bubbles and hold
// violations; the main sequence compares them to hand-derived values.
// -----------------------------------------------------------------------------
module tb_tx_frame_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_a = 1'b0, req_b = 1'b0;
   logic [15:0] len_a = 16'd0, len_b = 16'd0;
   logic        valid_a = 1'b1, valid_b = 1'b1;
   logic        mac_ready = 1'b1;
   logic [7:0]  data_a, data_b, mac_data;
   logic        rd_a, rd_b, mac_valid, mac_last, busy, err_len;
   logic [1:0]  gnt;

   int idx_a = 0, idx_b = 0;

   tx_frame_scheduler #(.MIN_LEN(64), .MAX_LEN(1518), .IFG_CYCLES(12)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .len_a(len_a), .data_a(data_a), .valid_a(valid_a), .rd_a(rd_a),
      .req_b(req_b), .len_b(len_b), .data_b(data_b), .valid_b(valid_b), .rd_b(rd_b),
      .gnt(gnt), .mac_data(mac_data), .mac_valid(mac_valid), .mac_last(mac_last),
      .mac_ready(mac_ready), .busy(busy), .err_len(err_len)
   );

   always #5 clk = ~clk;

   assign data_a = 8'(idx_a) + 8'h11;
   assign data_b = 8'(idx_b) + 8'h93;

   always @(posedge clk) begin
      if (rd_a) idx_a <= idx_a + 1;
      if (rd_b) idx_b <= idx_b + 1;
   end

   // ---------------- monitor ----------------
   logic [8:0] acc_q[$];
   logic [1:0] gnt_q[$];
   int         ifg_q[$];
   int         n_last = 0, ifg_run = 0, hold_viol = 0, bubbles = 0;
   logic [1:0] gnt_prev = 2'b00;
   logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
   logic [7:0] pd = 8'h00;

   always @(negedge clk) begin
      if (mac_valid && mac_ready) begin
         acc_q.push_back({mac_last, mac_data});
         if (mac_last) n_last <= n_last + 1;
      end
      if (gnt != 2'b00 && gnt_prev == 2'b00) gnt_q.push_back(gnt);
      gnt_prev <= gnt;
      if (gnt != 2'b00 && !mac_valid) bubbles <= bubbles + 1;
      if (busy && gnt == 2'b00) ifg_run <= ifg_run + 1;
      else if (ifg_run > 0) begin
         ifg_q.push_back(ifg_run);
         ifg_run <= 0;
      end
      if (pv && !pr && rst && (!mac_valid || mac_data != pd || mac_last != pl))
         hold_viol <= hold_viol + 1;
      pv <= mac_valid; pr <= mac_ready; pd <= mac_data; pl <= mac_last;
   end

   // ---------------- checking ----------------
   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // scan one frame from acc_q[s_acc] up to its mac_last
   task automatic chk_frame(input string tag, input int s_acc, input int len,
                            input bit is_b, input int s_idx);
      int tot, n, bad;
      bit fnd;
      logic [7:0] e;
      logic [8:0] w;
      tot = (len < 64) ? 64 : len;
      n = 0; bad = 0; fnd = 1'b0;
      for (int k = s_acc; k < acc_q.size() && !fnd; k++) begin
         w = acc_q[k];
         if (n >= len)  e = 8'h00;
         else if (is_b) e = 8'(s_idx + n) + 8'h93;
         else           e = 8'(s_idx + n) + 8'h11;
         if (w[7:0] !== e) bad++;
         n++;
         if (w[8]) fnd = 1'b1;
      end
      chk({tag, "_len"},  32'(n),   32'(tot));
      chk({tag, "_data"}, 32'(bad), 0);
      chk({tag, "_last"}, 32'(fnd), 1);
   endtask

   // wait until tgt_last frames have ended and the scheduler is idle again
   task automatic wait_done(input string tag, input int tgt_last, input int maxc);
      int c;
      c = 0;
      while ((n_last < tgt_last || busy) && c < maxc) begin
         @(negedge clk); #1;
         c++;
      end
      chk({tag, "_timeout"}, 32'(c < maxc), 1);
   endtask

   function automatic int last_ifg();
      return (ifg_q.size() > 0) ? ifg_q[ifg_q.size() - 1] : -1;
   endfunction

   // ---------------- sequence ----------------
   initial begin
      int s_acc, s_a, s_b, s_l, s_ifg, s_g, s_bub, c;
      bit done, st_r, st_v;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt",   32'(gnt), 0);
      chk("rst_valid", 32'(mac_valid), 0);
      chk("rst_last",  32'(mac_last), 0);
      chk("rst_data",  32'(mac_data), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_err",   32'(err_len), 0);
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);

      // T1: A only, 100 bytes
      s_acc = acc_q.size(); s_a = idx_a; s_l = n_last; s_ifg = ifg_q.size();
      @(posedge clk); #1; req_a = 1'b1; len_a = 16'd100;
      @(negedge clk); chk("t1_gnt_pre", 32'(gnt), 0);
      @(negedge clk); chk("t1_gnt", 32'(gnt), 1); chk("t1_busy", 32'(busy), 1);
      req_a = 1'b0; len_a = 16'd7;   // later length change must be ignored
      wait_done("t1", s_l + 1, 400);
      chk_frame("t1", s_acc, 100, 1'b0, s_a);
      chk("t1_total", 32'(acc_q.size() - s_acc), 100);
      chk("t1_rd", 32'(idx_a - s_a), 100);
      chk("t1_ifg_n", 32'(ifg_q.size() - s_ifg), 1);
      chk("t1_ifg", 32'(last_ifg()), 12);

      // T2: B only, 20 bytes padded to 64
      s_acc = acc_q.size(); s_b = idx_b; s_l = n_last;
      @(posedge clk); #1; req_b = 1'b1; len_b = 16'd20;
      @(negedge clk);
      @(negedge clk); chk("t2_gnt", 32'(gnt), 2);
      req_b = 1'b0;
      wait_done("t2", s_l + 1, 400);
      chk_frame("t2", s_acc, 20, 1'b1, s_b);
      chk("t2_total", 32'(acc_q.size() - s_acc), 64);
      chk("t2_rd", 32'(idx_b - s_b), 20);

      // T3: both held, 64 bytes each -> A,B,A,B
      s_acc = acc_q.size(); s_a = idx_a; s_b = idx_b; s_l = n_last;
      s_ifg = ifg_q.size(); s_g = gnt_q.size();
      @(posedge clk); #1; req_a = 1'b1; req_b = 1'b1; len_a = 16'd64; len_b = 16'd64;
      c = 0;
      while (gnt_q.size() - s_g < 4 && c < 2000) begin
         @(posedge clk); #1;
         c++;
      end
      chk("t3_gnt_timeout", 32'(c < 2000), 1);
      req_a = 1'b0; req_b = 1'b0;
      wait_done("t3", s_l + 4, 1000);
      for (int k = 0; k < 4 && s_g + k < gnt_q.size(); k++)
         chk("t3_order", 32'(gnt_q[s_g + k]), (k % 2 == 0) ? 1 : 2);
      chk_frame("t3f0", s_acc,       64, 1'b0, s_a);
      chk_frame("t3f1", s_acc + 64,  64, 1'b1, s_b);
      chk_frame("t3f2", s_acc + 128, 64, 1'b0, s_a + 64);
      chk_frame("t3f3", s_acc + 192, 64, 1'b1, s_b + 64);
      chk("t3_total", 32'(acc_q.size() - s_acc), 256);
      chk("t3_ifg_n", 32'(ifg_q.size() - s_ifg), 4);
      for (int k = 0; k < 4 && s_ifg + k < ifg_q.size(); k++)
         chk("t3_ifg", 32'(ifg_q[s_ifg + k]), 12);

      // T4: A 80 bytes, MAC stall at byte 10, source bubble near byte 40
      s_acc = acc_q.size(); s_a = idx_a; s_l = n_last; s_bub = bubbles;
      @(posedge clk); #1; req_a = 1'b1; len_a = 16'd80;
      @(negedge clk);
      @(negedge clk); chk("t4_gnt", 32'(gnt), 1);
      req_a = 1'b0;
      done = 1'b0; st_r = 1'b0; st_v = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(posedge clk); #1;
         if (!st_r && mac_valid && (acc_q.size() - s_acc) == 9) begin
            st_r = 1'b1;
            mac_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            chk("t4_hold_data",  32'(mac_data), 32'(8'(s_a + 9) + 8'h11));
            chk("t4_hold_valid", 32'(mac_valid), 1);
            chk("t4_hold_acc",   32'(acc_q.size() - s_acc), 9);
            mac_ready = 1'b1;
         end
         if (!st_v && (idx_a - s_a) == 39) begin
            st_v = 1'b1;
            valid_a = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            valid_a = 1'b1;
         end
         if (n_last > s_l) done = 1'b1;
      end
      wait_done("t4", s_l + 1, 200);
      chk("t4_stalls", 32'({st_r, st_v}), 3);
      chk_frame("t4", s_acc, 80, 1'b0, s_a);
      chk("t4_total", 32'(acc_q.size() - s_acc), 80);
      chk("t4_rd", 32'(idx_a - s_a), 80);
      chk("t4_bubbles", 32'(bubbles - s_bub), 4);

      // T5: illegal lengths, then a legal B request
      @(posedge clk); #1; req_a = 1'b1; len_a = 16'd0;
      @(negedge clk); chk("t5_err0_pre", 32'(err_len), 0);
      @(negedge clk); chk("t5_err0", 32'(err_len), 1); chk("t5_gnt0", 32'(gnt), 0);
      req_a = 1'b0;
      @(negedge clk); chk("t5_err0_off", 32'(err_len), 0); chk("t5_busy0", 32'(busy), 0);
      @(posedge clk); #1; req_a = 1'b1; len_a = 16'd2000;
      @(negedge clk);
      @(negedge clk); chk("t5_err1", 32'(err_len), 1); chk("t5_gnt1", 32'(gnt), 0);
      req_a = 1'b0;
      @(negedge clk); chk("t5_err1_off", 32'(err_len), 0);
      s_acc = acc_q.size(); s_b = idx_b; s_l = n_last;
      @(posedge clk); #1; req_b = 1'b1; len_b = 16'd30;
      @(negedge clk);
      @(negedge clk); chk("t5_gnt_b", 32'(gnt), 2);
      req_b = 1'b0;
      wait_done("t5", s_l + 1, 400);
      chk_frame("t5", s_acc, 30, 1'b1, s_b);
      chk("t5_rd", 32'(idx_b - s_b), 30);

      // T6: reset at byte 30 of a 100-byte frame, then a fresh frame
      s_acc = acc_q.size(); s_l = n_last;
      @(posedge clk); #1; req_a = 1'b1; len_a = 16'd100;
      @(negedge clk);
      @(negedge clk); chk("t6_gnt", 32'(gnt), 1);
      req_a = 1'b0;
      c = 0;
      while ((acc_q.size() - s_acc) < 29 && c < 500) begin
         @(posedge clk); #1;
         c++;
      end
      chk("t6_reach_timeout", 32'(c < 500), 1);
      rst = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(mac_valid), 0);
      chk("t6_rst_last",  32'(mac_last), 0);
      chk("t6_rst_gnt",   32'(gnt), 0);
      chk("t6_rst_busy",  32'(busy), 0);
      chk("t6_rst_data",  32'(mac_data), 0);
      chk("t6_rst_rd",    32'(rd_a), 0);
      repeat (2) @(negedge clk);
      chk("t6_no_last", 32'(n_last - s_l), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      s_acc = acc_q.size(); s_a = idx_a; s_l = n_last;
      @(posedge clk); #1; req_a = 1'b1; len_a = 16'd64;
      @(negedge clk);
      @(negedge clk); chk("t6_gnt2", 32'(gnt), 1);
      req_a = 1'b0;
      wait_done("t6", s_l + 1, 400);
      chk_frame("t6", s_acc, 64, 1'b0, s_a);
      chk("t6_rd", 32'(idx_a - s_a), 64);

      chk("hold_stable", 32'(hold_viol), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
